// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: bundle between the UART receive path / CPU core side and the
// program loader.
//   master : drives the receive side (rx_prog, rx_data, rx_data_v) and observes the
//            memory write port plus the status flags.
//   slave  : the loader itself.
// Signals:
//   rx_prog      load-mode request (level)
//   rx_data      received byte
//   rx_data_v    1-cycle strobe, rx_data valid
//   mem_addr     write byte address (ADDR_WIDTH bits)
//   mem_wr_data  write word {hi,lo}
//   mem_wr       1-cycle write strobe
//   mem_byt      byte-access select (the loader always does word writes)
//   cpu_hold     hold CPU in reset / loader owns the memory port
//   busy         frame in progress
//   done / err   sticky frame result
//   word_cnt     words written in the current/last frame
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

interface uart_prog_loader_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH
);
  logic                  rx_prog;
  logic [7:0]            rx_data;
  logic                  rx_data_v;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wr_data;
  logic                  mem_wr;
  logic                  mem_byt;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [15:0]           word_cnt;

  modport master (
    output rx_prog, rx_data, rx_data_v,
    input  mem_addr, mem_wr_data, mem_wr, mem_byt, cpu_hold, busy, done, err, word_cnt
  );

  modport slave (
    input  rx_prog, rx_data, rx_data_v,
    output mem_addr, mem_wr_data, mem_wr, mem_byt, cpu_hold, busy, done, err, word_cnt
  );
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time program loader sitting between the UART receiver and
// program memory. While rx_prog is high it parses a frame
//   N_hi, N_lo, N x {hi, lo}, [checksum]
// and writes each big-endian word to LOAD_BASE + 2*i, holding the CPU in reset.
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   bus        uart_prog_loader_if.slave (receive side in, memory write port and
//              status flags out)
// Build option:
//   UART_PROG_LOADER_CKSUM_EN  when defined, a trailing checksum byte (8-bit sum of
//              all data bytes) must match for the frame to finish in DONE.
// Parameters:
//   ADDR_WIDTH  byte-address width of the memory port
//   LOAD_BASE   byte address of the first loaded word (even)
//   MAX_WORDS   largest accepted word count
//   GAP_CYCLES  max idle clocks between bytes once the length high byte arrived
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module uart_prog_loader #(
  parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 'h300,
  parameter logic [15:0]           MAX_WORDS  = 16'h0E80,
  parameter int                    GAP_CYCLES = 20000
) (
  input logic              clk,
  input logic              rst,
  uart_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
`ifdef UART_PROG_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once the last word (or a zero length) has been taken.
`ifdef UART_PROG_LOADER_CKSUM_EN
  localparam state_t S_TAIL       = S_CKSUM;
  localparam bit     TAIL_IS_DONE = 1'b0;
`else
  localparam state_t S_TAIL       = S_DONE;
  localparam bit     TAIL_IS_DONE = 1'b1;
`endif

  localparam int             GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t                state;
  logic [15:0]           len_q;
  logic [7:0]            hi_q;
  logic [GW-1:0]         gap_cnt;
`ifdef UART_PROG_LOADER_CKSUM_EN
  logic [7:0]            acc_q;
`endif
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [15:0]           mem_wr_data_q;
  logic                  mem_wr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [15:0]           word_cnt_q;
  logic                  hold_state;

  // NOTE: every register below is updated with <= so all of them sample the
  // pre-edge values together; blocking assignments here would chain updates
  // within one edge and change behaviour depending on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      len_q         <= '0;
      hi_q          <= '0;
      gap_cnt       <= '0;
`ifdef UART_PROG_LOADER_CKSUM_EN
      acc_q         <= '0;
`endif
      mem_addr_q    <= LOAD_BASE;
      mem_wr_data_q <= '0;
      mem_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.rx_prog) state <= S_LEN_HI;

        // The host may sit here indefinitely; no gap timer yet.
        S_LEN_HI: begin
          if (!bus.rx_prog) begin
            state <= S_IDLE;
          end else if (bus.rx_data_v) begin
            len_q[15:8] <= bus.rx_data;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            word_cnt_q  <= '0;
            gap_cnt     <= '0;
`ifdef UART_PROG_LOADER_CKSUM_EN
            acc_q       <= '0;
`endif
            busy_q      <= 1'b1;
            state       <= S_LEN_LO;
          end
        end

        S_DONE, S_ERROR: if (!bus.rx_prog) state <= S_IDLE;

        // In-frame states: abort beats byte beats gap timeout.
        default: begin
          if (!bus.rx_prog) begin
            state  <= S_IDLE;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end else if (bus.rx_data_v) begin
            gap_cnt <= '0;
            case (state)
              S_LEN_LO: begin
                len_q[7:0] <= bus.rx_data;
                if ({len_q[15:8], bus.rx_data} > MAX_WORDS) begin
                  state  <= S_ERROR;
                  err_q  <= 1'b1;
                  busy_q <= 1'b0;
                end else if ({len_q[15:8], bus.rx_data} == 16'd0) begin
                  state  <= S_TAIL;
                  done_q <= TAIL_IS_DONE;
                  busy_q <= !TAIL_IS_DONE;
                end else begin
                  state <= S_DAT_HI;
                end
              end
              S_DAT_HI: begin
                hi_q  <= bus.rx_data;
`ifdef UART_PROG_LOADER_CKSUM_EN
                acc_q <= acc_q + bus.rx_data;
`endif
                state <= S_DAT_LO;
              end
              S_DAT_LO: begin
                // Write strobe, address and data all appear on the next cycle.
                mem_wr_q      <= 1'b1;
                mem_addr_q    <= LOAD_BASE + ADDR_WIDTH'({word_cnt_q, 1'b0});
                mem_wr_data_q <= {hi_q, bus.rx_data};
                word_cnt_q    <= word_cnt_q + 16'd1;
`ifdef UART_PROG_LOADER_CKSUM_EN
                acc_q         <= acc_q + bus.rx_data;
`endif
                if (word_cnt_q + 16'd1 == len_q) begin
                  state  <= S_TAIL;
                  done_q <= TAIL_IS_DONE;
                  busy_q <= !TAIL_IS_DONE;
                end else begin
                  state <= S_DAT_HI;
                end
              end
`ifdef UART_PROG_LOADER_CKSUM_EN
              S_CKSUM: begin
                busy_q <= 1'b0;
                if (bus.rx_data == acc_q) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                end else begin
                  state <= S_ERROR;
                  err_q <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end else if (gap_cnt == GAP_LAST) begin
            state  <= S_ERROR;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign hold_state = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

  // cpu_hold follows rx_prog combinationally so the CPU is held from the very
  // first cycle of a load request; it is forced low while rst is asserted.
  assign bus.cpu_hold    = !rst && (bus.rx_prog || hold_state);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_byt     = 1'b0;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: self-checking bench for uart_prog_loader.
// Table of frame records plus randomized frames checked against a frame-level
// model (expected write list and checksum from plain arithmetic), plus hand
// sequences for latency, gap timeout, abort and asynchronous reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module tb_uart_prog_loader;
  localparam int             AW   = `ADDR_WIDTH;
  localparam logic [AW-1:0]  BASE = 'h300;
  localparam int             MAXW = 'h0E80;
  localparam int             GAP  = 20000;
`ifdef UART_PROG_LOADER_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_prog_loader #(
    .ADDR_WIDTH(AW),
    .LOAD_BASE (BASE),
    .MAX_WORDS (16'(MAXW)),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    string name;
    int    n;
    bit    bad;
    bit    done;
    bit    err;
    int    cnt;
  } vec_t;

  wr_t        wr_q[$];    // observed writes
  wr_t        exp_q[$];   // model writes
  logic [7:0] data_q[$];  // data bytes of the current frame
  vec_t       tbl[$];
  wr_t        mon_w;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      mon_w.addr = bus.mem_addr;
      mon_w.data = bus.mem_wr_data;
      wr_q.push_back(mon_w);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_vec(input string name, input int n, input bit bad,
                                  input bit done, input bit err, input int cnt);
    vec_t v;
    v.name = name; v.n = n; v.bad = bad; v.done = done; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  // Frame-level reference: word i goes to BASE+2i (mod 2^AW) as {byte 2i, byte 2i+1}.
  function automatic void model_writes(input int n);
    wr_t w;
    exp_q.delete();
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        w.addr = BASE + AW'(2 * i);
        w.data = {data_q[2*i], data_q[2*i+1]};
        exp_q.push_back(w);
      end
    end
  endfunction

  function automatic logic [7:0] model_cksum();
    int s = 0;
    foreach (data_q[i]) s += int'(data_q[i]);
    return 8'(s);
  endfunction

  function automatic void model_status(input int n, input bit bad,
                                       output bit done, output bit err, output int cnt);
    if (n > MAXW)           begin done = 0; err = 1; cnt = 0; end
    else if (CK_EN && bad)  begin done = 0; err = 1; cnt = n; end
    else                    begin done = 1; err = 0; cnt = n; end
  endfunction

  // Caller is at a falling edge; back-to-back calls with idle=0 keep the strobe high.
  task automatic send_byte(input logic [7:0] b, input int idle);
    bus.rx_data   = b;
    bus.rx_data_v = 1'b1;
    @(negedge clk);
    bus.rx_data_v = 1'b0;
    bus.rx_data   = 8'($urandom);
    repeat (idle) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.rx_prog = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    data_q.delete();
    bus.rx_prog = 1'b1;
    @(negedge clk);
  endtask

  task automatic compare_writes(input string name);
    check({name, " wr_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check($sformatf("%s wr%0d addr", name, i), wr_q[i].addr, exp_q[i].addr);
      check($sformatf("%s wr%0d data", name, i), wr_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] ck;
    int         mi;
    int         nwr;
    mi = (v.n > 64) ? 0 : 3;
    start_frame();
    send_byte(8'(v.n >> 8), $urandom_range(0, mi));
    send_byte(8'(v.n), $urandom_range(0, mi));
    if (v.n <= MAXW) begin
      for (int i = 0; i < 2 * v.n; i++) begin
        data_q.push_back(8'($urandom));
        send_byte(data_q[i], $urandom_range(0, mi));
      end
      if (CK_EN) begin
        ck = model_cksum();
        if (v.bad) ck = ck + 8'd1;
        send_byte(ck, 0);
      end
    end
    model_writes(v.n);
    repeat (3) @(negedge clk);
    check({v.name, " done"}, bus.done, v.done);
    check({v.name, " err"}, bus.err, v.err);
    check({v.name, " word_cnt"}, bus.word_cnt, v.cnt);
    check({v.name, " busy"}, bus.busy, 0);
    check({v.name, " cpu_hold"}, bus.cpu_hold, 1);
    check({v.name, " mem_byt"}, bus.mem_byt, 0);
    compare_writes(v.name);
    // Bytes arriving after the frame ends are ignored.
    nwr = wr_q.size();
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 2);
    check({v.name, " ignored_bytes"}, wr_q.size(), nwr);
    check({v.name, " done_held"}, bus.done, v.done);
    bus.rx_prog = 1'b0;
    #1;
    check({v.name, " cpu_hold_release"}, bus.cpu_hold, 0);
    @(negedge clk);
    check({v.name, " done_sticky"}, bus.done, v.done);
  endtask

  initial begin
    bit   m_done, m_err;
    int   m_cnt;
    vec_t rv;

    tbl.push_back(mk_vec("one_word",   1,        0, 1,      0,     1));
    tbl.push_back(mk_vec("zero_len",   0,        0, 1,      0,     0));
    tbl.push_back(mk_vec("five_words", 5,        0, 1,      0,     5));
    tbl.push_back(mk_vec("bad_cksum",  3,        1, !CK_EN, CK_EN, 3));
    tbl.push_back(mk_vec("over_max",   MAXW + 1, 0, 0,      1,     0));
    tbl.push_back(mk_vec("len_ffff",   'hFFFF,   0, 0,      1,     0));
    tbl.push_back(mk_vec("max_words",  MAXW,     0, 1,      0,     MAXW));

    rst           = 1'b1;
    bus.rx_prog   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_data_v = 1'b0;
    repeat (3) @(negedge clk);
    check("rst mem_addr", bus.mem_addr, BASE);
    check("rst mem_wr", bus.mem_wr, 0);
    check("rst mem_wr_data", bus.mem_wr_data, 0);
    check("rst cpu_hold", bus.cpu_hold, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst err", bus.err, 0);
    check("rst word_cnt", bus.word_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Strobes while idle do nothing.
    send_byte(8'h00, 0);
    send_byte(8'h01, 2);
    check("idle busy", bus.busy, 0);
    check("idle writes", wr_q.size(), 0);
    check("idle cpu_hold", bus.cpu_hold, 0);

    // Two-word frame with latency checks; AB arrives in the first write cycle.
    start_frame();
    send_byte(8'h00, 0);
    send_byte(8'h02, 1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("t1 w0 mem_wr", bus.mem_wr, 1);
    check("t1 w0 addr", bus.mem_addr, 'h300);
    check("t1 w0 data", bus.mem_wr_data, 'h1234);
    check("t1 w0 word_cnt", bus.word_cnt, 1);
    check("t1 busy", bus.busy, 1);
    bus.rx_data   = 8'hAB;
    bus.rx_data_v = 1'b1;
    @(negedge clk);
    bus.rx_data   = 8'hCD;
    @(posedge clk);
    #1;
    check("t1 w1 mem_wr", bus.mem_wr, 1);
    check("t1 w1 addr", bus.mem_addr, 'h302);
    check("t1 w1 data", bus.mem_wr_data, 'hABCD);
    check("t1 w1 word_cnt", bus.word_cnt, 2);
    @(negedge clk);
    bus.rx_data_v = 1'b0;
    if (CK_EN) send_byte(8'hBE, 0);
    repeat (2) @(negedge clk);
    check("t1 mem_wr_pulse", bus.mem_wr, 0);
    check("t1 done", bus.done, 1);
    check("t1 err", bus.err, 0);
    check("t1 word_cnt", bus.word_cnt, 2);
    check("t1 wr_count", wr_q.size(), 2);
    bus.rx_prog = 1'b0;
    #1;
    check("t1 cpu_hold_drop", bus.cpu_hold, 0);

    // Table-driven frames.
    foreach (tbl[i]) run_frame(tbl[i]);

    // Randomized frames, expectations from the model.
    for (int i = 0; i < 20; i++) begin
      rv.n   = $urandom_range(0, 16);
      rv.bad = ($urandom_range(0, 3) == 0);
      model_status(rv.n, rv.bad, m_done, m_err, m_cnt);
      rv.name = $sformatf("rnd%0d", i);
      rv.done = m_done;
      rv.err  = m_err;
      rv.cnt  = m_cnt;
      run_frame(rv);
    end

    // Silence after two of three words: error exactly GAP clocks after the last byte.
    start_frame();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    repeat (GAP - 1) @(posedge clk);
    #1;
    check("gap err_before", bus.err, 0);
    check("gap busy_before", bus.busy, 1);
    @(posedge clk);
    #1;
    check("gap err_at", bus.err, 1);
    check("gap busy_at", bus.busy, 0);
    check("gap word_cnt", bus.word_cnt, 2);
    check("gap wr_count", wr_q.size(), 2);

`ifdef UART_PROG_LOADER_CKSUM_EN
    start_frame();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
    send_byte(8'h02, 0); send_byte(8'h04, 2);
    check("ck_bad err", bus.err, 1);
    check("ck_bad done", bus.done, 0);
    start_frame();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
    send_byte(8'h02, 0); send_byte(8'h03, 2);
    check("ck_good done", bus.done, 1);
    check("ck_good err", bus.err, 0);
`endif

    // rx_prog drops after the high byte of word 2.
    start_frame();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    bus.rx_prog = 1'b0;
    @(posedge clk);
    #1;
    check("abort err", bus.err, 1);
    check("abort busy", bus.busy, 0);
    check("abort cpu_hold", bus.cpu_hold, 0);
    check("abort word_cnt", bus.word_cnt, 1);
    @(negedge clk);
    send_byte(8'h44, 4);
    check("abort wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) check("abort wr0 data", wr_q[0].data, 'h1122);

    // Asynchronous reset mid-frame.
    start_frame();
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    check("midrst busy_before", bus.busy, 1);
    check("midrst word_cnt_before", bus.word_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst mem_addr", bus.mem_addr, BASE);
    check("midrst mem_wr", bus.mem_wr, 0);
    check("midrst mem_wr_data", bus.mem_wr_data, 0);
    check("midrst cpu_hold", bus.cpu_hold, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst err", bus.err, 0);
    check("midrst word_cnt", bus.word_cnt, 0);
    check("midrst wr_count", wr_q.size(), 1);
    @(negedge clk);
    bus.rx_prog = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
